prog_loader: RTL and testbench
==============================

// Module: prog_loader
// PURPOSE
//  Byte-stream program loader sitting upstream of cpu_top: receives a framed program image over a
//  valid/ready byte interface and writes it into the 32x8 CPU memory (8-bit instr {op[2:0],addr[4:0]}).
//  Holds the CPU in reset while loading, verifies a checksum, then releases the CPU.
//  Re-asserts CPU reset on halt so the next frame can be loaded.
// PARAMETERS
//  ADDR_WIDTH  5   memory address width; memory depth = 2**ADDR_WIDTH
//  DATA_WIDTH  8   memory word / stream byte width
// PORTS
//  clk        in   1           system clock, all logic on rising edge
//  rst        in   1           synchronous, active-high reset
//  in_valid   in   1           stream byte valid
//  in_data    in   DATA_WIDTH  stream byte
//  in_ready   out  1           loader accepts in_data this cycle (handshake = in_valid & in_ready)
//  mem_we     out  1           memory write strobe to CPU memory port
//  mem_addr   out  ADDR_WIDTH  memory write address
//  mem_wdata  out  DATA_WIDTH  memory write data
//  cpu_halt   in   1           halt output of cpu_top
//  cpu_rst    out  1           reset to cpu_top (active-high)
//  done       out  1           high while the loaded program runs
//  error      out  1           frame error flag (sticky until flush byte)
// BEHAVIOUR
//  Reset: state=IDLE, in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, cpu_rst=1, done=0, error=0.
//  rst dominates all other inputs; reset mid-frame discards the frame, memory contents untouched.
//  Frame: LEN byte, BASE byte, LEN payload bytes, CSUM byte. CSUM = sum(payload) mod 256.
//  All state changes happen only on accepted bytes (in_valid & in_ready); in_valid low = stall.
//  FSM:
//   IDLE : in_ready=1. Accept LEN. LEN==0 or LEN>2**ADDR_WIDTH -> ERR; else store LEN -> BASE.
//   BASE : in_ready=1. Accept byte; base=byte[ADDR_WIDTH-1:0] (upper bits ignored), cnt=0, sum=0 -> DATA.
//   DATA : in_ready=1. Per byte: next cycle mem_we=1, mem_addr=(base+cnt) mod 2**ADDR_WIDTH,
//          mem_wdata=byte; sum+=byte (mod 256); cnt++. After LEN-th byte -> CHECK.
//   CHECK: in_ready=1. Accept CSUM. Match -> RUN; mismatch -> ERR.
//   RUN  : in_ready=0, cpu_rst=0, done=1 (both registered, first cycle after CSUM accept).
//          cpu_halt=1 -> IDLE next cycle: cpu_rst=1, done=0.
//   ERR  : in_ready=1, error=1, cpu_rst=1; bytes discarded. Accepted byte 8'h00 -> IDLE, error=0.
//  mem_we is a 1-cycle pulse, registered: exactly one write per payload byte, 1 cycle after accept.
//  mem_we=0 in all states except the cycle after a DATA accept; no writes in BASE/CHECK/ERR.
//  Address wrap: base+cnt wraps modulo memory depth (base=30, LEN=4 -> 30,31,0,1).
//  Memory writes done before a checksum mismatch are not undone; CPU stays in reset.
//  cpu_halt ignored outside RUN. cpu_rst never deasserts except in RUN.
//  Back-to-back bytes (in_valid held high) accepted every cycle with no bubbles.
// TESTING
//  T1 frame {03,00,A0,4B,C6,B1} -> mem[0..2]=A0,4B,C6; cpu_rst falls 1 cyc after CSUM; done=1.
//  T2 load the 12-instr/6-data add/and/xor program (LEN=24, base 0) -> cpu runs; halt -> cpu_rst=1,
//     mem[12]=0F, mem[15]=00, mem[18]=FF, in_ready=1 in IDLE.
//  T3 frame {02,05,11,22,00} (bad csum, expect 33) -> error=1, cpu_rst=1; send 00 -> IDLE, error=0.
//  T4 LEN=00 and LEN=21h -> ERR on LEN byte, no mem_we ever pulses.
//  T5 frame {04,1E,01,02,03,04,0A} -> writes at 1E,1F,00,01; in_valid gaps of 0-3 cycles same result.
//  T6 rst pulse during DATA (after 2 of 4 bytes) -> all outputs at reset values next cycle, IDLE.

Source files
------------

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : prog_loader
// Brief    : Framed byte-stream loader for the CPU memory; keeps the CPU in
//            reset until the payload checksum verifies, re-arms on halt.
// Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
   parameter int ADDR_WIDTH = 5,
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  in_ready,
   output logic                  mem_we,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic                  cpu_halt,
   output logic                  cpu_rst,
   output logic                  done,
   output logic                  error
);

   localparam int unsigned DEPTH = 32'd1 << ADDR_WIDTH;

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_BASE  = 3'd1,
      S_DATA  = 3'd2,
      S_CHECK = 3'd3,
      S_RUN   = 3'd4,
      S_ERR   = 3'd5
   } state_e;

   state_e                state_q, state_d;
   logic [DATA_WIDTH-1:0] len_q, len_d;
   logic [DATA_WIDTH-1:0] cnt_q, cnt_d;
   logic [DATA_WIDTH-1:0] sum_q, sum_d;
   logic [ADDR_WIDTH-1:0] base_q, base_d;
   logic                  mem_we_q, mem_we_d;
   logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
   logic                  cpu_rst_q, cpu_rst_d;
   logic                  done_q, done_d;
   logic                  error_q, error_d;

   logic                  accept;
   logic                  len_bad;
   logic [DATA_WIDTH-1:0] cnt_inc;

   // The loader only stops listening while the CPU owns the memory.
   assign in_ready = (state_q != S_RUN);
   assign accept   = in_valid & in_ready;
   assign cnt_inc  = cnt_q + 1'b1;
   assign len_bad  = (in_data == '0) || (32'(in_data) > DEPTH);

   always_comb begin
      state_d     = state_q;
      len_d       = len_q;
      cnt_d       = cnt_q;
      sum_d       = sum_q;
      base_d      = base_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      cpu_rst_d   = cpu_rst_q;
      done_d      = done_q;
      error_d     = error_q;

      case (state_q)
         S_IDLE: begin
            if (accept) begin
               if (len_bad) begin
                  state_d = S_ERR;
                  error_d = 1'b1;
               end else begin
                  len_d   = in_data;
                  state_d = S_BASE;
               end
            end
         end
         S_BASE: begin
            if (accept) begin
               base_d  = in_data[ADDR_WIDTH-1:0];
               cnt_d   = '0;
               sum_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (accept) begin
               // Address arithmetic is ADDR_WIDTH wide so it wraps at the memory depth.
               mem_we_d    = 1'b1;
               mem_addr_d  = base_q + cnt_q[ADDR_WIDTH-1:0];
               mem_wdata_d = in_data;
               sum_d       = sum_q + in_data;
               cnt_d       = cnt_inc;
               if (cnt_inc == len_q) begin
                  state_d = S_CHECK;
               end
            end
         end
         S_CHECK: begin
            if (accept) begin
               if (in_data == sum_q) begin
                  state_d   = S_RUN;
                  cpu_rst_d = 1'b0;
                  done_d    = 1'b1;
               end else begin
                  state_d = S_ERR;
                  error_d = 1'b1;
               end
            end
         end
         S_RUN: begin
            if (cpu_halt) begin
               state_d   = S_IDLE;
               cpu_rst_d = 1'b1;
               done_d    = 1'b0;
            end
         end
         S_ERR: begin
            if (accept && (in_data == '0)) begin
               state_d = S_IDLE;
               error_d = 1'b0;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         len_q       <= '0;
         cnt_q       <= '0;
         sum_q       <= '0;
         base_q      <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         cpu_rst_q   <= 1'b1;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         len_q       <= len_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         base_q      <= base_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         cpu_rst_q   <= cpu_rst_d;
         done_q      <= done_d;
         error_q     <= error_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign cpu_rst   = cpu_rst_q;
   assign done      = done_q;
   assign error     = error_q;

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_loader
// Brief    : Self-checking bench for prog_loader against a frame-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_loader;

   localparam int AW    = 5;
   localparam int DW    = 8;
   localparam int DEPTH = 32;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          in_valid = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic          cpu_halt = 1'b0;
   logic          in_ready;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic          cpu_rst;
   logic          done;
   logic          error;

   prog_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .cpu_halt  (cpu_halt),
      .cpu_rst   (cpu_rst),
      .done      (done),
      .error     (error)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int exp_wr = 0;

   // Memory seen by the CPU, fed only by the loader's write port.
   logic [7:0] dut_mem [DEPTH];
   logic [7:0] ref_mem [DEPTH];
   logic [4:0] wr_log [$];
   int         wr_count = 0;
   int         cyc = 0;
   bit         clear_mem = 1'b1;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (clear_mem) begin
         for (int i = 0; i < DEPTH; i++) dut_mem[i] = 8'h00;
      end else if (mem_we) begin
         dut_mem[mem_addr] = mem_wdata;
         wr_count++;
         wr_log.push_back(mem_addr);
      end
   end

   task automatic send_byte(input logic [7:0] b, input int gap, output int waited);
      waited = 0;
      repeat (gap) begin
         in_valid = 1'b0;
         @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      if (!in_ready) begin
         tests++; fails++;
         $display("FAIL handshake_timeout byte %h in_ready got %b want 1", b, in_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic send_stream(input logic [7:0] f[$], input int maxgap);
      int w;
      foreach (f[i]) send_byte(f[i], (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0, w);
      in_valid = 1'b0;
   endtask

   function automatic void make_frame(input logic [7:0] base, input logic [7:0] pl[$],
                                      input bit corrupt, output logic [7:0] f[$]);
      int s;
      s = 0;
      f = {};
      f.push_back(8'(pl.size()));
      f.push_back(base);
      foreach (pl[i]) begin
         f.push_back(pl[i]);
         s = s + int'(pl[i]);
      end
      f.push_back(corrupt ? (8'(s % 256) ^ 8'h5A) : 8'(s % 256));
   endfunction

   // Frame-level reference: applies the payload to the expected memory and reports error.
   task automatic model_frame(input logic [7:0] f[$], output bit err);
      int len, base, s;
      len = int'(f[0]);
      err = 1'b1;
      if (len == 0 || len > DEPTH) return;
      base = int'(f[1]) % DEPTH;
      s = 0;
      for (int i = 0; i < len; i++) begin
         ref_mem[(base + i) % DEPTH] = f[2 + i];
         s = s + int'(f[2 + i]);
         exp_wr++;
      end
      err = ((s % 256) != int'(f[2 + len]));
   endtask

   task automatic check_mem(input string tag);
      int bad;
      bad = -1;
      for (int i = 0; i < DEPTH; i++)
         if (dut_mem[i] !== ref_mem[i] && bad < 0) bad = i;
      tests++;
      if (bad >= 0) begin
         fails++;
         $display("FAIL %s mem[%0d] got %h want %h", tag, bad, dut_mem[bad], ref_mem[bad]);
      end
      tests++;
      if (wr_count !== exp_wr) begin
         fails++;
         $display("FAIL %s write_count got %0d want %0d", tag, wr_count, exp_wr);
      end
   endtask

   // Checks the post-frame outputs, then returns the loader to IDLE (halt or flush).
   task automatic finish_frame(input bit exp_err, input string tag);
      int w;
      tests++;
      if ({cpu_rst, done, error, in_ready} !== {exp_err, !exp_err, exp_err, exp_err}) begin
         fails++;
         $display("FAIL %s end_flags {rst,done,err,rdy} got %b%b%b%b want %b%b%b%b", tag,
                  cpu_rst, done, error, in_ready, exp_err, !exp_err, exp_err, exp_err);
      end
      if (!exp_err) begin
         cpu_halt = 1'b1;
         @(posedge clk); #1;
         cpu_halt = 1'b0;
      end else begin
         repeat ($urandom_range(2, 0)) send_byte(8'($urandom_range(255, 1)), 0, w);
         send_byte(8'h00, 0, w);
         in_valid = 1'b0;
      end
      tests++;
      if ({cpu_rst, done, error, in_ready} !== 4'b1001) begin
         fails++;
         $display("FAIL %s idle_flags {rst,done,err,rdy} got %b%b%b%b want 1001", tag,
                  cpu_rst, done, error, in_ready);
      end
      check_mem(tag);
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      clear_mem = 1'b0;
      tests++;
      if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, error} !== {1'b1, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL reset_state got rdy=%b we=%b a=%h d=%h crst=%b done=%b err=%b want 1 0 00 00 1 0 0",
                  in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, error);
      end
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single_frame();
      logic [7:0] f[$];
      bit e;
      f = {8'h03, 8'h00, 8'hA0, 8'h4B, 8'hC6, 8'hB1};
      model_frame(f, e);
      send_stream(f, 0);
      tests++;
      if ({dut_mem[0], dut_mem[1], dut_mem[2]} !== 24'hA04BC6) begin
         fails++;
         $display("FAIL t1_mem got %h%h%h want a04bc6", dut_mem[0], dut_mem[1], dut_mem[2]);
      end
      finish_frame(e, "t1_frame");
   endtask

   task automatic test_back_to_back();
      logic [7:0] pl[$], f[$];
      bit e;
      int start, w, waits;
      waits = 0;
      for (int i = 0; i < 4; i++) pl.push_back(8'($urandom));
      make_frame(8'h08, pl, 1'b0, f);
      model_frame(f, e);
      start = cyc;
      foreach (f[i]) begin
         send_byte(f[i], 0, w);
         waits += w;
      end
      in_valid = 1'b0;
      tests++;
      if ((cyc - start) !== f.size() || waits !== 0) begin
         fails++;
         $display("FAIL back_to_back cycles got %0d want %0d (stalls %0d)", cyc - start, f.size(), waits);
      end
      finish_frame(e, "back_to_back");
   endtask

   task automatic test_full_program();
      logic [7:0] pl[$], f[$];
      bit e;
      for (int i = 0; i < 24; i++) pl.push_back(8'($urandom));
      pl[12] = 8'h0F; pl[15] = 8'h00; pl[18] = 8'hFF;
      make_frame(8'h00, pl, 1'b0, f);
      model_frame(f, e);
      send_stream(f, 0);
      tests++;
      if ({dut_mem[12], dut_mem[15], dut_mem[18]} !== 24'h0F00FF) begin
         fails++;
         $display("FAIL t2_data got %h %h %h want 0f 00 ff", dut_mem[12], dut_mem[15], dut_mem[18]);
      end
      finish_frame(e, "t2_program");
   endtask

   task automatic test_bad_checksum();
      logic [7:0] f[$];
      bit e;
      f = {8'h02, 8'h05, 8'h11, 8'h22, 8'h00};
      model_frame(f, e);
      send_stream(f, 0);
      cpu_halt = 1'b1;
      @(posedge clk); #1;
      cpu_halt = 1'b0;
      tests++;
      if ({cpu_rst, error, done} !== 3'b110) begin
         fails++;
         $display("FAIL t3_halt_in_err {rst,err,done} got %b%b%b want 110", cpu_rst, error, done);
      end
      finish_frame(e, "t3_bad_csum");
   endtask

   task automatic test_bad_length();
      logic [7:0] lens[2];
      logic [7:0] f[$];
      bit e;
      lens[0] = 8'h00;
      lens[1] = 8'h21;
      foreach (lens[k]) begin
         f = {lens[k]};
         model_frame(f, e);
         send_stream(f, 0);
         tests++;
         if (e !== 1'b1 || error !== 1'b1) begin
            fails++;
            $display("FAIL t4_len_%h error got %b want 1", lens[k], error);
         end
         finish_frame(1'b1, "t4_bad_len");
      end
   endtask

   task automatic test_wrap_gaps();
      logic [7:0] f[$];
      bit e;
      int first;
      f = {8'h04, 8'h1E, 8'h01, 8'h02, 8'h03, 8'h04, 8'h0A};
      first = wr_log.size();
      model_frame(f, e);
      send_stream(f, 3);
      tests++;
      if (wr_log.size() !== first + 4) begin
         fails++;
         $display("FAIL t5_wrap writes got %0d want 4", wr_log.size() - first);
      end else if ({wr_log[first], wr_log[first+1], wr_log[first+2], wr_log[first+3]} !== 20'b11110_11111_00000_00001) begin
         fails++;
         $display("FAIL t5_wrap addrs got %h %h %h %h want 1e 1f 00 01",
                  wr_log[first], wr_log[first+1], wr_log[first+2], wr_log[first+3]);
      end
      finish_frame(e, "t5_wrap");
   endtask

   task automatic test_reset_mid_frame();
      logic [7:0] f[$];
      bit e;
      int w;
      f = {8'h04, 8'h10, 8'h5C, 8'hE7};
      foreach (f[i]) send_byte(f[i], 0, w);
      ref_mem[16] = 8'h5C;
      ref_mem[17] = 8'hE7;
      exp_wr += 2;
      in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      tests++;
      if ({in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, error} !== {1'b1, 1'b0, 5'd0, 8'd0, 1'b1, 1'b0, 1'b0}) begin
         fails++;
         $display("FAIL t6_reset got rdy=%b we=%b a=%h d=%h crst=%b done=%b err=%b want 1 0 00 00 1 0 0",
                  in_ready, mem_we, mem_addr, mem_wdata, cpu_rst, done, error);
      end
      rst = 1'b0;
      check_mem("t6_partial");
      f = {8'h01, 8'h03, 8'h77, 8'h77};
      model_frame(f, e);
      send_stream(f, 1);
      finish_frame(e, "t6_after_reset");
   endtask

   task automatic test_random();
      logic [7:0] pl[$], f[$];
      bit e;
      int kind, len;
      for (int n = 0; n < 25; n++) begin
         kind = int'($urandom_range(99, 0));
         if (kind < 15) begin
            f = {(kind < 5) ? 8'h00 : 8'($urandom_range(255, 33))};
         end else begin
            len = (kind < 25) ? DEPTH : int'($urandom_range(DEPTH, 1));
            pl = {};
            for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
            make_frame(8'($urandom), pl, (kind >= 85), f);
         end
         model_frame(f, e);
         send_stream(f, 3);
         finish_frame(e, $sformatf("rand_%0d", n));
      end
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) ref_mem[i] = 8'h00;
      test_reset();
      test_single_frame();
      test_back_to_back();
      test_full_program();
      test_bad_checksum();
      test_bad_length();
      test_wrap_gaps();
      test_reset_mid_frame();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
